amo_ctl: RTL and testbench
==========================

# amo_ctl

Atomic-sequence responder for the hart front end. It answers `amo_req` from the pre-decode stage, which splits each AMO into load / ALU / store micro-ops. It acquires and holds the data-bus lock for the whole read-modify-write. It also returns exactly one `amo_ack` per accepted micro-op, and owns the LR/SC reservation register used by `lr.w`/`sc.w`.

## Interface
Parameters:
- `ADDR_W`, default 64: effective address width.
- `RSV_TIMEOUT`, default 64: cycles a reservation survives. Used only with `AMO_RSV_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `amo_req`  in  1  current pre-decoded micro-op belongs to an AMO sequence.
- `ir`  in  32  expanded micro-op. Opcode [6:0]: 0000011 load, 0110011 ALU, 0100011 store.
- `stall`  in  1  pipeline stall; no micro-op is accepted while high.
- `amo_ack`  out  1  micro-op accepted; pre-decode advances its sequence counter on this edge.
- `lock_req`  out  1  bus-lock request to the L1 arbiter.
- `lock_gnt`  in  1  arbiter grant; level, held while `lock_hold` is high.
- `lock_hold`  out  1  bus locked for this hart.
- `st_done`  in  1  one-cycle pulse: locked store has committed to L1.
- `lr_set`  in  1  one-cycle pulse: `lr.w` executed at `mem_addr`.
- `sc_chk`  in  1  one-cycle pulse: `sc.w` executing at `mem_addr`.
- `mem_addr`  in  ADDR_W  effective address accompanying `lr_set` / `sc_chk`.
- `sc_vld`  out  1  `sc_ok` valid, one cycle.
- `sc_ok`  out  1  1 = store-conditional succeeds.
- `snoop_inv`  in  1  remote write/invalidate pulse at `snoop_addr`.
- `snoop_addr`  in  ADDR_W  invalidated address.
- `rsv_valid`  out  1  reservation held.

## Operation
- FSM states and transitions:
  - IDLE: `amo_req` high → LOCK.
  - LOCK: `lock_req`=1; `lock_gnt` → OP.
  - OP: accept micro-ops; store micro-op accepted → DRAIN.
  - DRAIN: `st_done` → IDLE.
- Opcode handling in OP:
  - load or ALU micro-op: `amo_ack` when `!stall`, stay in OP.
  - Store micro-op follows load directly for `amoswap`; no ALU step is required.
  - Any other opcode: no ack. Micro-op is stalled at pre-decode.
- `lock_hold` = state ∈ {OP, DRAIN}. `lock_req` = state == LOCK.
- Abort: `amo_req` low in LOCK or OP → IDLE next cycle and the lock is dropped. In DRAIN, `amo_req` is ignored; exit only on `st_done`.
- Reservation:
  - Key is `mem_addr[ADDR_W-1:2]` (word granule).
  - `lr_set` sets `rsv_valid` and stores the key.
  - `sc_chk` checks, then always clears the reservation.
  - Cleared by matching `snoop_inv`, by any AMO store accepted in OP whose key matches, or by timeout.
- Same-cycle priority:
  - `sc_chk` evaluates the pre-edge reservation.
  - `lr_set` then installs a new one, beating `sc_chk` clear, snoop clear and timeout in the same cycle.
  - Snoop and timeout clear otherwise.

## Timing
- Reset values: `amo_ack`, `lock_req`, `lock_hold`, `sc_vld`, `sc_ok`, `rsv_valid` all 0. State IDLE, timeout counter 0. Reset mid-sequence drops the lock immediately (next cycle).
- `amo_ack` is Mealy: `state==OP && amo_req && !stall && opcode legal`. It is high for exactly one non-stalled cycle per micro-op and never in two consecutive cycles for the same micro-op.
- Earliest first ack: 2 cycles after `amo_req` rises (IDLE→LOCK, grant in LOCK). Grant latency adds cycle-for-cycle.
- `sc_vld`/`sc_ok` are registered, 1 cycle after `sc_chk`. `rsv_valid` updates 1 cycle after its cause.
- `lock_hold` falls the cycle after `st_done`.

## Configuration
- `AMO_RSV_TIMEOUT_EN` defined:
  - 8-bit-min counter runs while `rsv_valid`.
  - Reaching `RSV_TIMEOUT` clears the reservation.
  - Counter reloads to 0 on every `lr_set`.
- Undefined: no counter. A reservation persists until cleared by `sc_chk`, snoop or a matching AMO store.

## Test plan
- amoadd sequence, `lock_gnt` tied 1, no stall → `lock_req` at cycle 1. Acks at cycles 2, 3, 4 (load, ALU, store). `lock_hold` cycles 2 until 1 after `st_done`.
- amoswap with `stall` high on cycle 3 → load ack cycle 2, store ack cycle 4. No ack during stall, exactly 2 acks total.
- `lr_set` @0x1000, then `sc_chk` @0x1002 → `sc_vld`=1, `sc_ok`=1 one cycle later. Second `sc_chk` @0x1000 → `sc_ok`=0.
- `lr_set` @0x2000 with `snoop_inv` @0x2000 on the same cycle → `rsv_valid`=1. Later `snoop_inv` @0x2000 → 0. `snoop_inv` @0x2004 → unchanged.
- `AMO_RSV_TIMEOUT_EN`, `RSV_TIMEOUT`=4 → `rsv_valid` clears 4 cycles after `lr_set`. Without the macro it stays 1 for 100 cycles.
- `amo_req` dropped in OP after load ack → IDLE and `lock_hold`=0 next cycle. `rst_n`=0 in DRAIN → all outputs 0 next cycle.

Source files
------------

// File: rtl/amo_ctl_if.sv
// amo_ctl_if -- bundle between pre-decode / L1 arbiter / LSU and amo_ctl.
//
// Signals (direction as seen by amo_ctl through the slave modport):
//   amo_req    in   micro-op belongs to an AMO sequence
//   ir         in   expanded micro-op, opcode in [6:0]
//   stall      in   pipeline stall, blocks acceptance
//   amo_ack    out  micro-op accepted
//   lock_req   out  bus-lock request to the L1 arbiter
//   lock_gnt   in   arbiter grant (level)
//   lock_hold  out  bus locked for this hart
//   st_done    in   locked store committed to L1 (pulse)
//   lr_set     in   lr.w executed at mem_addr (pulse)
//   sc_chk     in   sc.w executing at mem_addr (pulse)
//   mem_addr   in   effective address for lr_set / sc_chk / AMO store
//   sc_vld     out  sc_ok valid (one cycle)
//   sc_ok      out  store-conditional succeeds
//   snoop_inv  in   remote write/invalidate (pulse)
//   snoop_addr in   invalidated address
//   rsv_valid  out  reservation held
interface amo_ctl_if #(
  parameter int ADDR_W = 64
);
  logic              amo_req;
  logic [31:0]       ir;
  logic              stall;
  logic              amo_ack;
  logic              lock_req;
  logic              lock_gnt;
  logic              lock_hold;
  logic              st_done;
  logic              lr_set;
  logic              sc_chk;
  logic [ADDR_W-1:0] mem_addr;
  logic              sc_vld;
  logic              sc_ok;
  logic              snoop_inv;
  logic [ADDR_W-1:0] snoop_addr;
  logic              rsv_valid;

  modport slave (
    input  amo_req, ir, stall, lock_gnt, st_done, lr_set, sc_chk, mem_addr,
           snoop_inv, snoop_addr,
    output amo_ack, lock_req, lock_hold, sc_vld, sc_ok, rsv_valid
  );

  modport master (
    output amo_req, ir, stall, lock_gnt, st_done, lr_set, sc_chk, mem_addr,
           snoop_inv, snoop_addr,
    input  amo_ack, lock_req, lock_hold, sc_vld, sc_ok, rsv_valid
  );
endinterface

// File: rtl/amo_ctl.sv
// amo_ctl -- atomic-sequence responder for the hart front end.
//
// Acquires the data-bus lock for an AMO read-modify-write, acks each
// load / ALU / store micro-op handed over by pre-decode, and owns the
// LR/SC reservation register.
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  synchronous active-low reset
//   bus    amo_ctl_if.slave (see amo_ctl_if.sv for the signal list)
//
// Parameters:
//   ADDR_W       effective address width
//   RSV_TIMEOUT  cycles a reservation survives (timeout build only)
//
// Build option:
//   AMO_RSV_TIMEOUT_EN  when defined, a reservation expires RSV_TIMEOUT
//                       cycles after it is installed. Undefined: it lives
//                       until sc.w, a matching snoop or a matching AMO store.
module amo_ctl #(
  parameter int ADDR_W      = 64,
  parameter int RSV_TIMEOUT = 64
) (
  input logic      clk,
  input logic      rst_n,
  amo_ctl_if.slave bus
);

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ALU = 7'b0110011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam int         KEY_W   = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    OP    = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Micro-op decode
  // ---------------------------------------------------------------------------
  logic [6:0] opc;
  logic       op_ld, op_alu, op_st, op_legal;

  assign opc = bus.ir[6:0];

  always_comb begin
    op_ld    = (opc == OPC_LD);
    op_alu   = (opc == OPC_ALU);
    op_st    = (opc == OPC_ST);
    op_legal = op_ld | op_alu | op_st;
  end

  // ---------------------------------------------------------------------------
  // Sequence FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  logic ack;
  logic lock_req;
  logic lock_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.amo_req) state_d = LOCK;
      // Dropping amo_req before the store is accepted aborts the sequence
      // and releases the bus on the next edge.
      LOCK: begin
        if (!bus.amo_req)      state_d = IDLE;
        else if (bus.lock_gnt) state_d = OP;
      end
      OP: begin
        if (!bus.amo_req)      state_d = IDLE;
        else if (ack && op_st) state_d = DRAIN;
      end
      // Once the store is handed over, the lock is held until it commits
      // regardless of amo_req.
      DRAIN: if (bus.st_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lock_req  = (state_q == LOCK);
    lock_hold = (state_q == OP) || (state_q == DRAIN);
    // Mealy ack: pre-decode advances on this, so an illegal opcode or a
    // stalled cycle simply holds the micro-op in place.
    ack       = (state_q == OP) && bus.amo_req && !bus.stall && op_legal;
  end

  assign bus.amo_ack   = ack;
  assign bus.lock_req  = lock_req;
  assign bus.lock_hold = lock_hold;

  // ---------------------------------------------------------------------------
  // LR/SC reservation (word granule)
  // ---------------------------------------------------------------------------
  logic [KEY_W-1:0] key_in, snp_key;
  logic [KEY_W-1:0] rsv_key_q, rsv_key_d;
  logic             rsv_valid_q, rsv_valid_d;
  logic             sc_vld_q, sc_vld_d;
  logic             sc_ok_q, sc_ok_d;
  logic             rsv_hit, snp_hit, st_hit, tmo_hit;

  assign key_in  = bus.mem_addr[ADDR_W-1:2];
  assign snp_key = bus.snoop_addr[ADDR_W-1:2];

`ifdef AMO_RSV_TIMEOUT_EN
  localparam int CNT_W = ($clog2(RSV_TIMEOUT + 1) > 8) ? $clog2(RSV_TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;

  // Counter holds the age of the reservation; it restarts at 0 with every
  // lr_set and expires the reservation when it would reach RSV_TIMEOUT,
  // so rsv_valid stays high for exactly RSV_TIMEOUT cycles.
  always_comb begin
    tmo_cnt_inc = tmo_cnt_q + 1'b1;
    tmo_hit     = rsv_valid_q && (tmo_cnt_inc == CNT_W'(RSV_TIMEOUT));
    tmo_cnt_d   = '0;
    if (!bus.lr_set && rsv_valid_q) tmo_cnt_d = tmo_cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^RSV_TIMEOUT;
`endif

  always_comb begin
    rsv_hit  = rsv_valid_q && (rsv_key_q == key_in);
    snp_hit  = bus.snoop_inv && rsv_valid_q && (rsv_key_q == snp_key);
    // An AMO store to the reserved word breaks the reservation.
    st_hit   = ack && op_st && rsv_hit;

    // sc.w judges the reservation as it stood before this edge.
    sc_vld_d = bus.sc_chk;
    sc_ok_d  = bus.sc_chk && rsv_hit;

    rsv_valid_d = rsv_valid_q;
    rsv_key_d   = rsv_key_q;
    if (bus.sc_chk || snp_hit || st_hit || tmo_hit) rsv_valid_d = 1'b0;
    // A new lr.w wins over every clear in the same cycle.
    if (bus.lr_set) begin
      rsv_valid_d = 1'b1;
      rsv_key_d   = key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsv_valid_q <= 1'b0;
      rsv_key_q   <= '0;
      sc_vld_q    <= 1'b0;
      sc_ok_q     <= 1'b0;
    end else begin
      rsv_valid_q <= rsv_valid_d;
      rsv_key_q   <= rsv_key_d;
      sc_vld_q    <= sc_vld_d;
      sc_ok_q     <= sc_ok_d;
    end
  end

  assign bus.rsv_valid = rsv_valid_q;
  assign bus.sc_vld    = sc_vld_q;
  assign bus.sc_ok     = sc_ok_q;

  // Only the opcode and the word-granule address bits matter here.
  logic unused_bits;
  assign unused_bits = ^{bus.ir[31:7], bus.mem_addr[1:0], bus.snoop_addr[1:0]};

endmodule

// File: tb/tb_amo_ctl.sv
module tb_amo_ctl;
  localparam int AW = 64;
`ifdef AMO_RSV_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  localparam logic [31:0] IR_LD  = 32'h0000_2003;
  localparam logic [31:0] IR_ALU = 32'h0000_0033;
  localparam logic [31:0] IR_ST  = 32'h0000_2023;
  localparam logic [31:0] IR_BAD = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  amo_ctl_if #(.ADDR_W(AW)) bus ();
  amo_ctl #(.ADDR_W(AW), .RSV_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the outputs must be, from the sequence/reservation
  // rules. ph: 0 idle, 1 waiting for grant, 2 accepting micro-ops, 3 store
  // in flight.
  // ---------------------------------------------------------------------------
  int               m_ph  = 0;
  bit               m_rsv = 0;
  logic [63:0]      m_key = '0;
  int               m_age = 0;
  bit               m_vld = 0;
  bit               m_ok  = 0;

  function automatic bit legal(input logic [6:0] o);
    return o == IR_LD[6:0] || o == IR_ALU[6:0] || o == IR_ST[6:0];
  endfunction

  function automatic bit f_ack();
    return m_ph == 2 && bus.amo_req && !bus.stall && legal(bus.ir[6:0]);
  endfunction

  function automatic bit f_tmo();
`ifdef AMO_RSV_TIMEOUT_EN
    return m_rsv && (m_age + 1 == TMO);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("amo_ack",   bus.amo_ack,   f_ack());
      chk("lock_req",  bus.lock_req,  m_ph == 1);
      chk("lock_hold", bus.lock_hold, m_ph == 2 || m_ph == 3);
      chk("sc_vld",    bus.sc_vld,    m_vld);
      chk("sc_ok",     bus.sc_ok,     m_ok);
      chk("rsv_valid", bus.rsv_valid, m_rsv);
    end
    if (!rst_n) begin
      m_ph <= 0; m_rsv <= 0; m_key <= '0; m_age <= 0; m_vld <= 0; m_ok <= 0;
    end else begin
      case (m_ph)
        0: if (bus.amo_req) m_ph <= 1;
        1: m_ph <= !bus.amo_req ? 0 : (bus.lock_gnt ? 2 : 1);
        2: m_ph <= !bus.amo_req ? 0 : ((f_ack() && bus.ir[6:0] == IR_ST[6:0]) ? 3 : 2);
        default: if (bus.st_done) m_ph <= 0;
      endcase
      m_vld <= bus.sc_chk;
      m_ok  <= bus.sc_chk && m_rsv && (m_key == (bus.mem_addr >> 2));
      if (bus.lr_set) begin
        m_rsv <= 1; m_key <= bus.mem_addr >> 2; m_age <= 0;
      end else begin
        if (bus.sc_chk
            || (bus.snoop_inv && m_rsv && m_key == (bus.snoop_addr >> 2))
            || (f_ack() && bus.ir[6:0] == IR_ST[6:0] && m_rsv && m_key == (bus.mem_addr >> 2))
            || f_tmo())
          m_rsv <= 0;
        m_age <= m_rsv ? m_age + 1 : 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers
  // ---------------------------------------------------------------------------
  bit s_ack, s_lreq, s_hold, s_vld, s_ok, s_rsv;
  logic [7:0] av, lv, hv, vv, ov, rv;

  task automatic run_cycle();
    @(negedge clk);
    s_ack  = bus.amo_ack;  s_lreq = bus.lock_req; s_hold = bus.lock_hold;
    s_vld  = bus.sc_vld;   s_ok   = bus.sc_ok;    s_rsv  = bus.rsv_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses();
    bus.lr_set = 0; bus.sc_chk = 0; bus.snoop_inv = 0; bus.st_done = 0;
  endtask

  task automatic idle();
    clr_pulses();
    bus.amo_req = 0; bus.stall = 0; bus.lock_gnt = 1; bus.ir = IR_LD;
    run_cycle(); run_cycle();
    av = '0; lv = '0; hv = '0; vv = '0; ov = '0; rv = '0;
  endtask

  task automatic rec(input int c);
    av[c] = s_ack; lv[c] = s_lreq; hv[c] = s_hold;
    vv[c] = s_vld; ov[c] = s_ok;   rv[c] = s_rsv;
  endtask

  int cnt;

  initial begin
    rst_n = 0;
    clr_pulses();
    bus.amo_req = 0; bus.ir = IR_LD; bus.stall = 0; bus.lock_gnt = 0;
    bus.mem_addr = '0; bus.snoop_addr = '0;
    @(posedge clk); #1;
    chk_en = 1;
    run_cycle();
    chk("reset_outputs", {s_ack, s_lreq, s_hold, s_vld, s_ok, s_rsv}, 6'b0);
    rst_n = 1;

    // amoadd, grant tied high, no stall
    idle();
    for (int c = 0; c < 8; c++) begin
      clr_pulses();
      bus.amo_req = (c <= 4);
      bus.ir      = (c <= 2) ? IR_LD : (c == 3) ? IR_ALU : IR_ST;
      bus.st_done = (c == 6);
      run_cycle(); rec(c);
    end
    chk("amoadd_ack", av, 8'b0001_1100);
    chk("amoadd_lock_req", lv, 8'b0000_0010);
    chk("amoadd_lock_hold", hv, 8'b0111_1100);

    // amoswap, stall on cycle 3
    idle();
    for (int c = 0; c < 8; c++) begin
      clr_pulses();
      bus.amo_req = (c <= 4);
      bus.ir      = (c <= 2) ? IR_LD : IR_ST;
      bus.stall   = (c == 3);
      bus.st_done = (c == 5);
      run_cycle(); rec(c);
    end
    chk("amoswap_ack", av, 8'b0001_0100);
    chk("amoswap_ack_count", $countones(av), 2);
    chk("amoswap_lock_hold", hv, 8'b0011_1100);

    // lr.w / sc.w success then failure
    idle();
    for (int c = 0; c < 4; c++) begin
      clr_pulses();
      case (c)
        0: begin bus.lr_set = 1; bus.mem_addr = 64'h1000; end
        1: begin bus.sc_chk = 1; bus.mem_addr = 64'h1002; end
        2: begin bus.sc_chk = 1; bus.mem_addr = 64'h1000; end
        default: ;
      endcase
      run_cycle(); rec(c);
    end
    chk("lrsc_vld", vv, 8'b0000_1100);
    chk("lrsc_ok", ov, 8'b0000_0100);
    chk("lrsc_rsv", rv, 8'b0000_0010);

    // lr beats same-cycle snoop; non-matching snoop ignored; matching clears
    idle();
    for (int c = 0; c < 5; c++) begin
      clr_pulses();
      case (c)
        0: begin bus.lr_set = 1; bus.mem_addr = 64'h2000; bus.snoop_inv = 1; bus.snoop_addr = 64'h2000; end
        2: begin bus.snoop_inv = 1; bus.snoop_addr = 64'h2004; end
        3: begin bus.snoop_inv = 1; bus.snoop_addr = 64'h2000; end
        default: ;
      endcase
      run_cycle(); rec(c);
    end
    chk("snoop_rsv", rv, 8'b0000_1110);

    // lr beats same-cycle sc clear; sc still sees the old reservation
    idle();
    for (int c = 0; c < 5; c++) begin
      clr_pulses();
      bus.mem_addr = 64'h4000;
      bus.lr_set = (c <= 1);
      bus.sc_chk = (c == 1) || (c == 3);
      run_cycle(); rec(c);
    end
    chk("lr_vs_sc_ok", ov, 8'b0001_0100);
    chk("lr_vs_sc_rsv", rv, 8'b0000_1110);

    // matching AMO store clears the reservation
    idle();
    for (int c = 0; c < 6; c++) begin
      clr_pulses();
      bus.mem_addr = 64'h3000;
      bus.lr_set   = (c == 0);
      bus.amo_req  = (c <= 3);
      bus.ir       = (c <= 2) ? IR_LD : IR_ST;
      bus.st_done  = (c == 4);
      run_cycle(); rec(c);
    end
    chk("store_clr_rsv", rv, 8'b0000_1110);

    // grant latency, illegal opcode, abort in OP after load ack
    idle();
    for (int c = 0; c < 8; c++) begin
      clr_pulses();
      bus.amo_req  = (c <= 5);
      bus.lock_gnt = (c >= 3);
      bus.ir       = (c == 4) ? IR_BAD : IR_LD;
      run_cycle(); rec(c);
    end
    chk("latency_lock_req", lv, 8'b0000_1110);
    chk("latency_ack", av, 8'b0010_0000);
    chk("abort_op_hold", hv, 8'b0111_0000);

    // abort while waiting for grant
    idle();
    for (int c = 0; c < 5; c++) begin
      clr_pulses();
      bus.lock_gnt = 0;
      bus.amo_req  = (c <= 1);
      run_cycle(); rec(c);
    end
    chk("abort_lock_req", lv, 8'b0000_0110);
    chk("abort_lock_hold", hv, 8'b0);

    // reset while draining a store, with a live reservation and an sc.w
    idle();
    for (int c = 0; c < 7; c++) begin
      clr_pulses();
      rst_n        = (c != 4);
      bus.lr_set   = (c == 0);
      bus.mem_addr = (c == 0 || c == 4) ? 64'h7000 : 64'h8000;
      bus.amo_req  = (c <= 3);
      bus.ir       = (c <= 2) ? IR_LD : IR_ST;
      bus.sc_chk   = (c == 4);
      run_cycle(); rec(c);
    end
    chk("drain_hold_before_rst", hv[4], 1'b1);
    chk("drain_rsv_before_rst", rv[4], 1'b1);
    chk("after_rst_outputs", {av[5], lv[5], hv[5], vv[5], ov[5], rv[5]}, 6'b0);
    rst_n = 1;

    // reservation lifetime
    idle();
`ifdef AMO_RSV_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      clr_pulses();
      bus.lr_set = (c == 0); bus.mem_addr = 64'h9000;
      run_cycle(); rec(c);
    end
    chk("timeout_rsv", rv, 8'b0001_1110);
`else
    clr_pulses();
    bus.lr_set = 1; bus.mem_addr = 64'hA000;
    run_cycle();
    clr_pulses();
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      run_cycle();
      cnt += s_rsv;
    end
    chk("persist_100", cnt, 100);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
